// File: rtl/mem_stall_responder.sv
// Word-addressed 16-bit data memory with a fixed stall window per request.
// Each request ends in a one-cycle done pulse; unaligned requests flag err.
module mem_stall_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CW    = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   wr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [15:0]            wdata_q;
  logic [15:0]            data_out_q;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   complete;
  logic [15:0]            mem_q [DEPTH];

  logic                   unused_addr;
  assign unused_addr = ^addr[15:ADDR_BITS+1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d  = DONE;
          complete = 1'b1;
        end
      end
      IDLE, DONE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (addr[0]) begin
          // Unaligned: answer at once, no memory access.
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          state_d = BUSY;
          cnt_d   = CW'(LATENCY - 1);
          accept  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        wr_q    <= wr;
        idx_q   <= addr[ADDR_BITS:1];
        wdata_q <= data_in;
      end
      // Memory effect lands only on the BUSY->DONE edge.
      if (complete) begin
        if (wr_q) mem_q[idx_q] <= wdata_q;
        else      data_out_q   <= mem_q[idx_q];
      end
    end
  end

  assign stall    = (state_q == BUSY);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Directed bench for mem_stall_responder: per-cycle vectors with
// hand-computed outputs, plus a reset-abort sequence.
module tb_mem_stall_responder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  int n_vec;
  int n_bad;

  mem_stall_responder #(.ADDR_BITS(8), .LATENCY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .stall    (stall),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic        done;
    logic        err;
    logic [15:0] dout;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic e, input logic w,
    input logic [15:0] a, input logic [15:0] d,
    input logic s, input logic dn, input logic er,
    input logic [15:0] q
  );
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.addr = a; v.din = d;
    v.stall = s; v.done = dn; v.err = er; v.dout = q;
    return v;
  endfunction

  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    rst     = v.rst;
    enable  = v.en;
    wr      = v.wr;
    addr    = v.addr;
    data_in = v.din;
    @(posedge clk);
    #1;
    n_vec++;
    if (stall !== v.stall || done !== v.done ||
        err !== v.err || data_out !== v.dout) begin
      n_bad++;
      $display("FAIL %s: got stall=%b done=%b err=%b dout=%h, want stall=%b done=%b err=%b dout=%h",
               name, stall, done, err, data_out,
               v.stall, v.done, v.err, v.dout);
    end
  endtask

  vec_t tbl[30];

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;

    //            rst en wr addr      din       stl dn er dout
    tbl[0]  = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    // read 0x0010 after reset
    tbl[1]  = mk(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    // write BEEF @0x0004 (accepted from DONE)
    tbl[4]  = mk(0, 1, 1, 16'h0004, 16'hBEEF, 1, 0, 0, 16'h0000);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    // back-to-back read 0x0004
    tbl[7]  = mk(0, 1, 0, 16'h0004, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF);
    // write 5555 @0x0006: data_out must hold BEEF
    tbl[10] = mk(0, 1, 1, 16'h0006, 16'h5555, 1, 0, 0, 16'hBEEF);
    tbl[11] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF);
    tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF);
    // unaligned read 0x0005
    tbl[13] = mk(0, 1, 0, 16'h0005, 16'h0000, 0, 1, 1, 16'hBEEF);
    tbl[14] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF);
    // unaligned write 0x0007 must not touch word 3
    tbl[15] = mk(0, 1, 1, 16'h0007, 16'hDEAD, 0, 1, 1, 16'hBEEF);
    tbl[16] = mk(0, 1, 0, 16'h0006, 16'h0000, 1, 0, 0, 16'hBEEF);
    tbl[17] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF);
    tbl[18] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h5555);
    // write 1234 @0x0202 wraps to word 1
    tbl[19] = mk(0, 1, 1, 16'h0202, 16'h1234, 1, 0, 0, 16'h5555);
    tbl[20] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h5555);
    tbl[21] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h5555);
    tbl[22] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h5555);
    // read 0x0002; inputs toggled during BUSY are ignored
    tbl[23] = mk(0, 1, 0, 16'h0002, 16'h0000, 1, 0, 0, 16'h5555);
    tbl[24] = mk(0, 1, 1, 16'h0002, 16'hFFFF, 1, 0, 0, 16'h5555);
    tbl[25] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h1234);
    tbl[26] = mk(0, 1, 0, 16'h0002, 16'h0000, 1, 0, 0, 16'h1234);
    tbl[27] = mk(0, 1, 1, 16'h0002, 16'hAAAA, 1, 0, 0, 16'h1234);
    tbl[28] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h1234);
    tbl[29] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h1234);

    for (int i = 0; i < 30; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset during first BUSY cycle aborts the write and clears memory.
    apply("rstw_req",  mk(0, 1, 1, 16'h0008, 16'h1234, 1, 0, 0, 16'h1234));
    apply("rstw_rst",  mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000));
    apply("rd8_req",   mk(0, 1, 0, 16'h0008, 16'h0000, 1, 0, 0, 16'h0000));
    apply("rd8_busy",  mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    apply("rd8_done",  mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000));
    apply("rd2_req",   mk(0, 1, 0, 16'h0002, 16'h0000, 1, 0, 0, 16'h0000));
    apply("rd2_busy",  mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000));
    apply("rd2_clr",   mk(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000));

    // Reset in DONE after an unaligned request clears err at once.
    apply("ua_req",    mk(0, 1, 0, 16'h0003, 16'h0000, 0, 1, 1, 16'h0000));
    apply("ua_rst",    mk(1, 1, 0, 16'h0003, 16'h0000, 0, 0, 0, 16'h0000));
    apply("idle_end",  mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
